sysbus_mem_responder: RTL and testbench
=======================================

# sysbus_mem_responder

Sysbus memory-side responder: the target end of the fetch/request protocol driven by the core's fetch unit. It accepts line requests on the request channel, returns a 64-byte line as eight 64-bit beats on the response channel with the request tag echoed, and optionally absorbs 8-beat line writes. It sits between the bus and a behavioural word array, serving as the memory model for the core and its bench.

## Interface
- BUS_DATA_WIDTH, 64, beat width; only 64 is supported
- BUS_TAG_WIDTH, 13, tag width; bit [12] is 1 for read, 0 for write
- MEM_DEPTH, 4096, array size in 64-bit words; power of two, multiple of 8
- READ_LATENCY, 4, cycles from request accept to first response beat; ≥1

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- bus_reqcyc  in  1  request valid (address beat, then write-data beats)
- bus_reqack  out  1  request ready; transfer on reqcyc && reqack at posedge
- bus_req  in  64  byte address (address beat) or write data (data beats)
- bus_reqtag  in  13  request tag, sampled on the address beat
- bus_respcyc  out  1  response beat valid
- bus_respack  in  1  response beat accepted; transfer on respcyc && respack
- bus_resp  out  64  response data
- bus_resptag  out  13  captured request tag, held for all 8 beats

## Operation
- States: IDLE, LAT, RESP, WDATA.
- IDLE: reqack=1. On transfer, capture line index = bus_req[log2(MEM_DEPTH)+2:6], start word = bus_req[5:3], tag; bus_req[2:0] and bits above the index are ignored (aliasing). Tag[12]=1 → LAT; 0 → WDATA.
- LAT: reqack=0; down-counter loaded with READ_LATENCY-1; at 0 → RESP.
- RESP: respcyc=1, resp = mem[line*8 + ((start+beat) mod 8)], critical-word-first, wrapping within the line. Beat counter 0..7 advances on respack; after beat 7 is acked → IDLE. respcyc and data hold stable while respack=0.
- WDATA: reqack=1; each reqcyc transfer is one data beat, written to the same wrapped word sequence; after beat 7 → IDLE. No response phase for writes.
- Requests with reqcyc while not in IDLE/WDATA are not acked; the initiator holds them.
- Array contents are not cleared by reset.

## Timing
- Reset (reset=0 at posedge): state→IDLE, counters→0; reqack=0, respcyc=0, resp=0, resptag=0 while reset is low. reqack=1 in the first cycle after release.
- Reset mid-burst: burst abandoned, no further beats, array contents preserved (partial writes retained).
- Read latency: accept at edge E; respcyc first high in the cycle READ_LATENCY cycles later (READ_LATENCY=1 → cycle right after E).
- Back-to-back beats: respack at edge E_n → next beat's data valid in cycle after E_n, respcyc stays high; no bubble. Full line takes ≥8 cycles in RESP.
- Final respack → IDLE next cycle, reqack=1 then; next request accepted one cycle after the last beat at earliest.
- respack while respcyc=0 is ignored.
- Write beats: one per cycle max; reqcyc gaps allowed, counter holds.

## Configuration
- SYSBUS_MEM_WRITE_EN defined: WDATA beats are stored into the array.
- Undefined: write requests are still accepted and all 8 data beats acked and consumed, but data is discarded; array is read-only, protocol identical.

## Test plan
- Reset held 3 cycles with reqcyc=1 → reqack=0, respcyc=0 throughout; reqack=1 first cycle after release.
- Write (macro on) addr 0x1000 tag 0x0100, beats 0x11..0x88 → 9 acked transfers, no respcyc; then read 0x1000 tag 0x1100 (READ_LATENCY=4) → respcyc high 4 cycles after accept, beats 0x11..0x88, resptag=0x1100 every beat.
- Read 0x1028 of that line → beats 0x66,0x77,0x88,0x11,...,0x55 (wrap at word 5).
- respack withheld 5 cycles on beat 2 → respcyc and resp hold 0x33 unchanged; resumes at 0x44 cycle after ack.
- Reset asserted after beat 3 acked → respcyc=0 next cycle, state IDLE; re-read returns full line intact.
- Macro off: write 0xDEAD to 0x2000 line, read back → pre-existing contents, write still fully acked.

Source files
------------

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel bundle shared by the fetch-side initiator
// (master) and the memory responder (slave).
interface sysbus_mem_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: serves 64-byte lines critical-word-first from a word array.
// Define SYSBUS_MEM_WRITE_EN to let 8-beat line writes update the array.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_DEPTH      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int WORD_W = $clog2(MEM_DEPTH);
    localparam int LINE_W = WORD_W - 3;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

`ifdef SYSBUS_MEM_WRITE_EN
    localparam bit WRITES_ENABLED = 1'b1;
`else
    localparam bit WRITES_ENABLED = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LAT, RESP, WDATA} state_t;

    state_t                    state_q, state_d;
    logic [LINE_W-1:0]         lineIdx_q, lineIdx_d;
    logic [2:0]                startWord_q, startWord_d;
    logic [2:0]                beat_q, beat_d;
    logic [LAT_W-1:0]          latCnt_q, latCnt_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;

    logic                      reqAck;
    logic                      respCyc;
    logic                      memWe;
    logic [WORD_W-1:0]         wordAddr;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Beats walk the line from the start word and wrap inside the 8-word line.
    assign wordAddr = {lineIdx_q, 3'(startWord_q + beat_q)};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lineIdx_q   <= '0;
            startWord_q <= '0;
            beat_q      <= '0;
            latCnt_q    <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            lineIdx_q   <= lineIdx_d;
            startWord_q <= startWord_d;
            beat_q      <= beat_d;
            latCnt_q    <= latCnt_d;
            tag_q       <= tag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lineIdx_d   = lineIdx_q;
        startWord_d = startWord_q;
        beat_d      = beat_q;
        latCnt_d    = latCnt_q;
        tag_d       = tag_q;
        reqAck      = 1'b0;
        respCyc     = 1'b0;
        memWe       = 1'b0;

        unique case (state_q)
            IDLE: begin
                reqAck = 1'b1;
                if (bus.bus_reqcyc) begin
                    lineIdx_d   = bus.bus_req[WORD_W+2:6];
                    startWord_d = bus.bus_req[5:3];
                    tag_d       = bus.bus_reqtag;
                    beat_d      = '0;
                    if (!bus.bus_reqtag[BUS_TAG_WIDTH-1]) begin
                        state_d = WDATA;
                    end else if (READ_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d  = LAT;
                        latCnt_d = LAT_LOAD;
                    end
                end
            end
            LAT: begin
                if (latCnt_q <= LAT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    latCnt_d = latCnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                respCyc = 1'b1;
                if (bus.bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            WDATA: begin
                reqAck = 1'b1;
                if (bus.bus_reqcyc) begin
                    memWe  = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs stay quiet for as long as reset is held, not just after the reset edge.
        if (!reset) begin
            reqAck  = 1'b0;
            respCyc = 1'b0;
            memWe   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe && WRITES_ENABLED) begin
            mem[wordAddr] <= bus.bus_req;
        end
    end

    assign bus.bus_reqack  = reqAck;
    assign bus.bus_respcyc = respCyc;
    assign bus.bus_resp    = respCyc ? mem[wordAddr] : '0;
    assign bus.bus_resptag = reset ? tag_q : '0;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: line writes, wrapped reads,
// response back-pressure, aliasing and reset in the middle of a burst.
module tb_sysbus_mem_responder;
    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int DEPTH = 4096;
    localparam int RL    = 4;

`ifdef SYSBUS_MEM_WRITE_EN
    localparam bit WRITES_ON = 1'b1;
`else
    localparam bit WRITES_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] modelMem [DEPTH];
    logic [DW-1:0] expQ [$];
    logic [TW-1:0] expTag;

    sysbus_mem_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .MEM_DEPTH     (DEPTH),
        .READ_LATENCY  (RL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Address beat plus eight data beats; optional reqcyc gap after data beat gapAfter.
    task automatic applyWrite(input logic [63:0] addr, input logic [TW-1:0] tag,
                              input logic [7:0][63:0] data, input int gapAfter);
        int line;
        int sw;
        int guard;
        int acks;
        bit sawResp;
        line    = int'((addr >> 6) & 64'd511);
        sw      = int'((addr >> 3) & 64'd7);
        acks    = 0;
        sawResp = 1'b0;
        bus.bus_respack = 1'b0;
        bus.bus_reqcyc  = 1'b1;
        bus.bus_req     = addr;
        bus.bus_reqtag  = tag;
        for (int b = -1; b < 8; b++) begin
            if (b >= 0) bus.bus_req = data[b];
            guard = 0;
            while (bus.bus_reqack !== 1'b1 && guard < 20) begin
                if (bus.bus_respcyc === 1'b1) sawResp = 1'b1;
                stepCycle();
                guard++;
            end
            if (bus.bus_reqack === 1'b1) acks++;
            if (bus.bus_respcyc === 1'b1) sawResp = 1'b1;
            stepCycle();
            if (b >= 0 && WRITES_ON) modelMem[line*8 + ((sw + b) % 8)] = data[b];
            if (b == gapAfter) begin
                bus.bus_reqcyc = 1'b0;
                repeat (3) begin
                    if (bus.bus_respcyc === 1'b1) sawResp = 1'b1;
                    stepCycle();
                end
                bus.bus_reqcyc = 1'b1;
            end
        end
        bus.bus_reqcyc = 1'b0;
        checkOutput("wr_acks", 64'(acks), 64'd9);
        checkOutput("wr_no_resp", 64'(sawResp), 64'd0);
    endtask

    // Issues a read, checks first-beat latency, then consumes numBeats beats,
    // withholding respack for holdCycles cycles on beat holdBeat.
    task automatic applyRead(input logic [63:0] addr, input logic [TW-1:0] tag,
                             input int holdBeat, input int holdCycles, input int numBeats);
        int line;
        int sw;
        int guard;
        int lat;
        line = int'((addr >> 6) & 64'd511);
        sw   = int'((addr >> 3) & 64'd7);
        bus.bus_req     = addr;
        bus.bus_reqtag  = tag;
        bus.bus_reqcyc  = 1'b1;
        bus.bus_respack = 1'b1;
        guard = 0;
        while (bus.bus_reqack !== 1'b1 && guard < 20) begin
            stepCycle();
            guard++;
        end
        checkOutput("rd_req_ack", 64'(bus.bus_reqack), 64'd1);
        stepCycle();
        bus.bus_reqcyc = 1'b0;
        for (int b = 0; b < 8; b++) expQ.push_back(modelMem[line*8 + ((sw + b) % 8)]);
        expTag = tag;
        lat = 1;
        while (bus.bus_respcyc !== 1'b1 && lat < 40) begin
            stepCycle();
            lat++;
        end
        checkOutput("rd_latency", 64'(lat), 64'(RL));
        if (bus.bus_respcyc !== 1'b1) begin
            expQ.delete();
            return;
        end
        for (int n = 0; n < numBeats; n++) begin
            if (n == holdBeat) begin
                bus.bus_respack = 1'b0;
                for (int h = 0; h < holdCycles; h++) begin
                    checkOutput("hold_respcyc", 64'(bus.bus_respcyc), 64'd1);
                    checkOutput("hold_data", bus.bus_resp, expQ[0]);
                    stepCycle();
                end
                bus.bus_respack = 1'b1;
            end
            checkOutput("beat_respcyc", 64'(bus.bus_respcyc), 64'd1);
            checkOutput("beat_tag", 64'(bus.bus_resptag), 64'(expTag));
            checkOutput("beat_data", bus.bus_resp, expQ.pop_front());
            stepCycle();
        end
        if (numBeats == 8) begin
            checkOutput("rd_done_respcyc", 64'(bus.bus_respcyc), 64'd0);
            checkOutput("rd_done_reqack", 64'(bus.bus_reqack), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0][63:0] lineA;
        logic [7:0][63:0] lineB;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        for (int b = 0; b < 8; b++) begin
            lineA[b] = 64'h11 * 64'(b + 1);
            lineB[b] = 64'hDEAD0 + 64'(b);
        end

        reset           = 1'b0;
        bus.bus_reqcyc  = 1'b1;
        bus.bus_req     = 64'h1000;
        bus.bus_reqtag  = 13'h1100;
        bus.bus_respack = 1'b0;
        repeat (3) begin
            stepCycle();
            checkOutput("rst_reqack", 64'(bus.bus_reqack), 64'd0);
            checkOutput("rst_respcyc", 64'(bus.bus_respcyc), 64'd0);
            checkOutput("rst_resp", bus.bus_resp, 64'd0);
            checkOutput("rst_resptag", 64'(bus.bus_resptag), 64'd0);
        end
        reset          = 1'b1;
        bus.bus_reqcyc = 1'b0;
        stepCycle();
        checkOutput("rel_reqack", 64'(bus.bus_reqack), 64'd1);
        checkOutput("rel_respcyc", 64'(bus.bus_respcyc), 64'd0);

        applyWrite(64'h1000, 13'h0100, lineA, -1);
        applyRead(64'h1000, 13'h1100, -1, 0, 8);
        applyRead(64'h1028, 13'h1005, -1, 0, 8);
        applyRead(64'h1000, 13'h1222, 2, 5, 8);
        applyRead(64'h9005, 13'h1abc, 0, 2, 8);

        applyWrite(64'h2000, 13'h0042, lineB, 3);
        applyRead(64'h2038, 13'h1ff0, -1, 0, 8);

        applyRead(64'h1000, 13'h1333, -1, 0, 4);
        bus.bus_respack = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midrst_respcyc", 64'(bus.bus_respcyc), 64'd0);
        checkOutput("midrst_reqack", 64'(bus.bus_reqack), 64'd0);
        stepCycle();
        checkOutput("midrst_respcyc_edge", 64'(bus.bus_respcyc), 64'd0);
        reset = 1'b1;
        expQ.delete();
        stepCycle();
        checkOutput("midrst_idle_reqack", 64'(bus.bus_reqack), 64'd1);
        checkOutput("midrst_idle_respcyc", 64'(bus.bus_respcyc), 64'd0);
        applyRead(64'h1000, 13'h1444, -1, 0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
